// File: rtl/inst_buffer_if.sv
// Fetch-side and decode-side handshake bundle for the instruction buffer.
interface inst_buffer_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            in_ready;
    logic            out_ready;
    logic            out_valid;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_npc;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_npc
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_npc
    );
endinterface

// File: rtl/inst_buffer.sv
// Circular instruction queue between fetch and decode; presents entries in
// program order, applies backpressure, and empties itself on flush.
module inst_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    inst_buffer_if.slave           bus,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0]     inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             enq;
    logic             deq;

    // Handshake decode; no bypass in either direction.
    always_comb begin
        bus.in_ready  = (count != CNT_W'(DEPTH));
        bus.out_valid = (count != '0) && !flush;
        enq           = bus.in_valid && bus.in_ready && !flush;
        deq           = bus.out_valid && bus.out_ready;
    end

    // Head view; idle outputs show a NOP at PC 0 so decode never sees X.
    always_comb begin
        bus.out_inst = NOP;
        bus.out_pc   = '0;
        if (bus.out_valid) begin
            bus.out_inst = inst_mem[head];
            bus.out_pc   = pc_mem[head];
        end
        bus.out_npc = bus.out_pc + XLEN'(4);
    end

    // Entry storage carries no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem[tail] <= bus.in_inst;
            pc_mem[tail]   <= bus.in_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) tail <= tail + PTR_W'(1);
            if (deq) head <= head + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer.
module tb_inst_buffer;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned XLEN  = 32;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [3:0] count;
    int         passed;
    int         total;

    inst_buffer_if #(.XLEN(XLEN)) bus_if ();

    inst_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus_if.slave),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq_one(input logic [31:0] inst, input logic [31:0] pc);
        bus_if.in_valid = 1'b1;
        bus_if.in_inst  = inst;
        bus_if.in_pc    = pc;
        step();
        bus_if.in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] next_pc;
        int          deq_n;
        int          enq_n;
        int          cyc;

        passed = 0;
        total  = 0;
        reset  = 1'b1;
        flush  = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_inst   = '0;
        bus_if.in_pc     = '0;
        bus_if.out_ready = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
        chk("rst_out_inst", 64'(bus_if.out_inst), 64'h13);
        chk("rst_out_pc", 64'(bus_if.out_pc), 64'd0);
        chk("rst_out_npc", 64'(bus_if.out_npc), 64'd4);
        reset = 1'b0;
        step();

        // Reset mid-operation
        enq_one(32'h1111_1111, 32'h40);
        enq_one(32'h2222_2222, 32'h44);
        enq_one(32'h3333_3333, 32'h48);
        chk("mid_count3", 64'(count), 64'd3);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_valid", 64'(bus_if.out_valid), 64'd0);
        chk("mid_rst_inst", 64'(bus_if.out_inst), 64'h13);
        #1 reset = 1'b0;
        enq_one(32'h1234_5037, 32'h0);
        chk("lat_inst", 64'(bus_if.out_inst), 64'h1234_5037);
        chk("lat_pc", 64'(bus_if.out_pc), 64'h0);
        chk("lat_npc", 64'(bus_if.out_npc), 64'h4);
        chk("lat_count", 64'(count), 64'd1);
        bus_if.out_ready = 1'b1;
        step();
        bus_if.out_ready = 1'b0;
        chk("lat_drain", 64'(count), 64'd0);

        // Fill to full with decode stalled
        for (int i = 0; i < 8; i++) enq_one(32'hA000_0000 + 32'(i), 32'(i * 4));
        chk("full_count", 64'(count), 64'd8);
        chk("full_in_ready", 64'(bus_if.in_ready), 64'd0);
        enq_one(32'hDEAD_BEEF, 32'h20);
        chk("full_9th_count", 64'(count), 64'd8);
        chk("full_hold_pc", 64'(bus_if.out_pc), 64'h0);
        chk("full_hold_inst", 64'(bus_if.out_inst), 64'hA000_0000);

        // Drain in order
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", 64'(bus_if.out_valid), 64'd1);
            chk("drain_pc", 64'(bus_if.out_pc), 64'(i * 4));
            chk("drain_inst", 64'(bus_if.out_inst), 64'(32'hA000_0000 + 32'(i)));
            step();
        end
        chk("drain_empty_valid", 64'(bus_if.out_valid), 64'd0);
        chk("drain_empty_count", 64'(count), 64'd0);
        step();
        chk("empty_ignore_ready", 64'(count), 64'd0);
        bus_if.out_ready = 1'b0;

        // Simultaneous enqueue/dequeue at count 4
        for (int i = 0; i < 4; i++) enq_one(32'hB000_0000 + 32'(i), 32'h100 + 32'(i * 4));
        chk("sim_pre_count", 64'(count), 64'd4);
        bus_if.out_ready = 1'b1;
        enq_one(32'hB000_0004, 32'h110);
        chk("sim_count", 64'(count), 64'd4);
        chk("sim_head", 64'(bus_if.out_pc), 64'h104);
        for (int i = 0; i < 4; i++) begin
            chk("sim_drain_pc", 64'(bus_if.out_pc), 64'(32'h104 + 32'(i * 4)));
            step();
        end
        chk("sim_empty", 64'(count), 64'd0);
        bus_if.out_ready = 1'b0;

        // Wrap-around with alternating stalls on both sides
        exp_pc  = 32'h200;
        next_pc = 32'h200;
        deq_n   = 0;
        enq_n   = 0;
        cyc     = 0;
        while (deq_n < 20 && cyc < 400) begin
            bus_if.in_valid  = (enq_n < 20) && (cyc % 3 != 0);
            bus_if.in_inst   = 32'hC000_0000 + next_pc;
            bus_if.in_pc     = next_pc;
            bus_if.out_ready = (cyc % 2 == 1);
            #1;
            if (bus_if.out_valid && bus_if.out_ready) begin
                chk("wrap_pc", 64'(bus_if.out_pc), 64'(exp_pc));
                chk("wrap_inst", 64'(bus_if.out_inst), 64'(32'hC000_0000 + exp_pc));
                exp_pc = exp_pc + 32'd4;
                deq_n++;
            end
            if (bus_if.in_valid && bus_if.in_ready) begin
                next_pc = next_pc + 32'd4;
                enq_n++;
            end
            step();
            cyc++;
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        chk("wrap_dequeued", 64'(deq_n), 64'd20);
        chk("wrap_enqueued", 64'(enq_n), 64'd20);
        chk("wrap_empty", 64'(count), 64'd0);

        // Flush with concurrent enqueue at count 5
        for (int i = 0; i < 5; i++) enq_one(32'hD000_0000 + 32'(i), 32'h400 + 32'(i * 4));
        chk("flush_pre_count", 64'(count), 64'd5);
        bus_if.in_valid = 1'b1;
        bus_if.in_inst  = 32'hEEEE_EEEE;
        bus_if.in_pc    = 32'h500;
        flush = 1'b1;
        #1;
        chk("flush_cycle_valid", 64'(bus_if.out_valid), 64'd0);
        chk("flush_cycle_inst", 64'(bus_if.out_inst), 64'h13);
        step();
        flush = 1'b0;
        bus_if.in_valid = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(bus_if.out_valid), 64'd0);
        enq_one(32'hF000_0000, 32'h600);
        chk("flush_dropped_pc", 64'(bus_if.out_pc), 64'h600);
        chk("flush_dropped_count", 64'(count), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
